// File: rtl/y86_pkg.sv
// Shared Y86 constants, the fetch record layout and the bubble record used
// by the fetch queue.
package y86_pkg;

  localparam logic [3:0] STAT_AOK  = 4'd1;
  localparam logic [3:0] STAT_HLT  = 4'd2;
  localparam logic [3:0] STAT_ADR  = 4'd3;
  localparam logic [3:0] STAT_INS  = 4'd4;
  localparam logic [3:0] ICODE_NOP = 4'd1;
  localparam logic [3:0] RNONE     = 4'hF;

  localparam int Y86_REC_W = 148;
  localparam int STAT_LSB  = 144;
  localparam int ICODE_LSB = 140;
  localparam int IFUN_LSB  = 136;
  localparam int RA_LSB    = 132;
  localparam int RB_LSB    = 128;
  localparam int VALC_LSB  = 64;
  localparam int VALP_LSB  = 0;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } y86_rec_t;

  function automatic y86_rec_t bubble_rec();
    y86_rec_t r;
    r.stat  = STAT_AOK;
    r.icode = ICODE_NOP;
    r.ifun  = 4'h0;
    r.ra    = RNONE;
    r.rb    = RNONE;
    r.valc  = 64'h0;
    r.valp  = 64'h0;
    return r;
  endfunction

endpackage

// File: rtl/fq_ram.sv
// Fetch queue record storage: one write port, one asynchronous read port,
// contents are not reset.
module fq_ram
  import y86_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REC_W = Y86_REC_W
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [REC_W-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [REC_W-1:0]         rdata_o
);

  logic [REC_W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode record queue with fault freeze and flush.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards in_rec to out_rec when empty.
module fetch_queue
  import y86_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REC_W = Y86_REC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [REC_W-1:0]         in_rec,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [REC_W-1:0]         out_rec,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             frozen_q, frozen_d;
  logic             empty_s, full_s, push_s, pop_s, store_s, byp_s, bad_stat_s;
  logic [REC_W-1:0] rdata_s;

  fq_ram #(.DEPTH(DEPTH), .REC_W(REC_W)) u_ram (
    .clk     (clk),
    .we_i    (store_s && !flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_rec),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  // Handshake, head selection and next-state computation
  always_comb begin
    empty_s    = (count_q == CW'(0));
    full_s     = (count_q == CW'(DEPTH));
    in_ready   = !full_s && !frozen_q;
    push_s     = in_valid && in_ready;
    bad_stat_s = (in_rec[STAT_LSB +: 4] != STAT_AOK);
`ifdef FETCH_QUEUE_BYPASS_EN
    byp_s      = empty_s && !frozen_q && in_valid && !flush;
`else
    byp_s      = 1'b0;
`endif
    out_valid  = !empty_s || byp_s;
    if (!empty_s) begin
      out_rec = rdata_s;
    end else if (byp_s) begin
      out_rec = in_rec;
    end else begin
      out_rec = REC_W'(bubble_rec());
    end
    pop_s   = !empty_s && out_ready;
    // A bypassed record that decode takes immediately never occupies a slot
    store_s = push_s && !(byp_s && out_ready);

    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
      frozen_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(store_s);
      rd_ptr_d = rd_ptr_q + PW'(pop_s);
      count_d  = count_q + CW'(store_s) - CW'(pop_s);
      frozen_d = frozen_q || (push_s && bad_stat_s);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      frozen_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      frozen_q <= frozen_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [147:0] in_rec;
  logic         in_ready;
  logic         out_valid;
  logic [147:0] out_rec;
  logic         out_ready;
  logic         flush;
  logic [2:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [147:0] mq[$];
  logic         mfrozen = 1'b0;
  logic [147:0] bubble;

  fetch_queue #(.DEPTH(DEPTH), .REC_W(148)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_rec    (in_rec),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_rec   (out_rec),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [147:0] mk(input logic [3:0] stat, input logic [63:0] valp);
    return {stat, 4'h3, 4'h0, 4'h1, 4'h2, 64'h0000_0000_0000_00C0, valp};
  endfunction

  task automatic chk(input string nm, input logic [147:0] act, input logic [147:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic model_byp();
    return BYP && (mq.size() == 0) && !mfrozen && in_valid && !flush;
  endfunction

  // Per-cycle comparison against the reference queue
  always @(negedge clk) begin
    logic         e_valid;
    logic [147:0] e_rec;
    e_valid = (mq.size() != 0) || model_byp();
    e_rec   = (mq.size() != 0) ? mq[0] : (model_byp() ? in_rec : bubble);
    chk("cyc_count", 148'(count), 148'(mq.size()));
    chk("cyc_in_ready", 148'(in_ready), 148'((mq.size() < DEPTH) && !mfrozen));
    chk("cyc_out_valid", 148'(out_valid), 148'(e_valid));
    chk("cyc_out_rec", out_rec, e_rec);
  end

  task automatic model_update();
    logic acc, byp;
    if (flush) begin
      mq.delete();
      mfrozen = 1'b0;
    end else begin
      byp = model_byp();
      acc = in_valid && (mq.size() < DEPTH) && !mfrozen;
      if (byp && out_ready) begin
        // consumed straight through, never stored
      end else begin
        if (out_ready && mq.size() != 0) void'(mq.pop_front());
        if (acc) mq.push_back(in_rec);
      end
      if (acc && in_rec[147:144] != 4'd1) mfrozen = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input logic v, input logic [147:0] r, input logic rdy, input logic fl);
    in_valid  = v;
    in_rec    = r;
    out_ready = rdy;
    flush     = fl;
    tick();
  endtask

  initial begin
    bubble    = {4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_rec    = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_count", 148'(count), 148'(0));
    chk("rst_out_valid", 148'(out_valid), 148'(0));
    chk("rst_in_ready", 148'(in_ready), 148'(1));
    chk("rst_out_rec", out_rec, bubble);
    rst = 1'b0;

    // Three pushes held, then drained in order
    step(1'b1, mk(4'd1, 64'h0A), 1'b0, 1'b0);
    step(1'b1, mk(4'd1, 64'h14), 1'b0, 1'b0);
    step(1'b1, mk(4'd1, 64'h1E), 1'b0, 1'b0);
    chk("fifo_count3", 148'(count), 148'(3));
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("fifo_pop0", 148'(out_rec[63:0]), 148'(64'h0A));
    tick();
    chk("fifo_pop1", 148'(out_rec[63:0]), 148'(64'h14));
    tick();
    chk("fifo_pop2", 148'(out_rec[63:0]), 148'(64'h1E));
    tick();
    chk("fifo_bubble", out_rec, bubble);

    // Full queue: no push even with a concurrent pop, then wrap
    for (int i = 1; i <= 4; i++) step(1'b1, mk(4'd1, 64'(i)), 1'b0, 1'b0);
    chk("full_count", 148'(count), 148'(4));
    in_valid = 1'b1; in_rec = mk(4'd1, 64'h5); out_ready = 1'b1; #1;
    chk("full_in_ready", 148'(in_ready), 148'(0));
    tick();
    chk("full_pop_count", 148'(count), 148'(3));
    for (int i = 0; i < 6; i++) step(1'b1, mk(4'd1, 64'(6 + i)), 1'b1, 1'b0);
    chk("wrap_head", 148'(out_rec[63:0]), 148'(64'h9));
    chk("wrap_count", 148'(count), 148'(3));
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Faulting record freezes intake until flush
    step(1'b1, mk(4'd1, 64'h50), 1'b0, 1'b0);
    step(1'b1, mk(4'd2, 64'h60), 1'b0, 1'b0);
    chk("frz_in_ready", 148'(in_ready), 148'(0));
    step(1'b1, mk(4'd1, 64'h70), 1'b1, 1'b0);
    chk("frz_drain_head", 148'(out_rec[63:0]), 148'(64'h60));
    step(1'b1, mk(4'd1, 64'h70), 1'b1, 1'b0);
    chk("frz_drained", 148'(count), 148'(0));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("frz_hold", 148'(in_ready), 148'(0));
    step(1'b0, '0, 1'b0, 1'b1);
    chk("frz_flush_ready", 148'(in_ready), 148'(1));

    // Flush beats a concurrent push and pop
    for (int i = 0; i < 3; i++) step(1'b1, mk(4'd1, 64'(32 + i)), 1'b0, 1'b0);
    chk("fl_count3", 148'(count), 148'(3));
    step(1'b1, mk(4'd1, 64'h99), 1'b1, 1'b1);
    chk("fl_count", 148'(count), 148'(0));
    chk("fl_out_valid", 148'(out_valid), 148'(0));
    chk("fl_in_ready", 148'(in_ready), 148'(1));
    chk("fl_out_rec", out_rec, bubble);

    // Asynchronous reset between edges
    step(1'b1, mk(4'd1, 64'hA1), 1'b0, 1'b0);
    step(1'b1, mk(4'd1, 64'hA2), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("arst_pre", 148'(count), 148'(2));
    rst = 1'b1; #1;
    chk("arst_count", 148'(count), 148'(0));
    chk("arst_out_valid", 148'(out_valid), 148'(0));
    mq.delete(); mfrozen = 1'b0;
    #1 rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);

`ifdef FETCH_QUEUE_BYPASS_EN
    in_valid = 1'b1; in_rec = mk(4'd1, 64'h40); out_ready = 1'b1; #1;
    chk("byp_valid", 148'(out_valid), 148'(1));
    chk("byp_valp", 148'(out_rec[63:0]), 148'(64'h40));
    tick();
    chk("byp_count", 148'(count), 148'(0));
`else
    in_valid = 1'b1; in_rec = mk(4'd1, 64'h40); out_ready = 1'b1; #1;
    chk("nobyp_valid", 148'(out_valid), 148'(0));
    tick();
    in_valid = 1'b0; #1;
    chk("nobyp_lat1", 148'(out_rec[63:0]), 148'(64'h40));
    chk("nobyp_count", 148'(count), 148'(1));
`endif
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
